// File: rtl/spi_dac_multi_master.sv
// SPI write master for a multi-channel DAC (32-bit command frames, MSB first).
// A request in IDLE captures channel and code into the shift register; the frame
// then runs LOAD (one cycle, cs low) -> SHIFT (32 bits) -> GAP (cs high) -> IDLE.
// Optional feature: define SPI_DAC_INIT_EN to send an internal-reference-on frame
// (32'h08000001) after every reset before any request is accepted.
module spi_dac_multi_master #(
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned NUM_CH  = 8,
    parameter int unsigned CLK_DIV = 50,
    parameter bit          CPOL    = 1'b1
) (
    input  logic              clk_100mhz,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        ch_addr,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              sclk,
    output logic              mosi,
    output logic              cs
);

    localparam int unsigned DivW    = $clog2(CLK_DIV);
    localparam int unsigned DataLsb = 20 - DATA_W;

    typedef enum logic [2:0] {
        StIdle,
`ifdef SPI_DAC_INIT_EN
        StInit,
`endif
        StLoad,
        StShift,
        StGap
    } state_e;

    state_e            state_q, state_d;
    logic [DivW-1:0]   div_q, div_d;
    logic              phase_q, phase_d;   // 0: first half of bit (sclk = CPOL)
    logic [4:0]        bit_q, bit_d;
    logic [31:0]       shreg_q, shreg_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              init_q, init_d;     // current frame is the init frame (no done)

    logic              addr_ok;
    logic              div_last;
    logic [31:0]       frame;

    assign addr_ok  = (32'(ch_addr) < NUM_CH) || (ch_addr == 4'hF);
    assign div_last = (div_q == DivW'(CLK_DIV - 1));
    assign frame    = {8'h03, ch_addr, 20'h0_0000} | (32'(data_in) << DataLsb);

    // Next-state logic: frame sequencing and divider/bit counting.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        init_d  = init_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (addr_ok) begin
                        shreg_d = frame;
                        init_d  = 1'b0;
                        state_d = StLoad;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
`ifdef SPI_DAC_INIT_EN
            StInit: begin
                shreg_d = 32'h0800_0001;
                init_d  = 1'b1;
                state_d = StLoad;
            end
`endif
            StLoad: begin
                div_d   = '0;
                phase_d = 1'b0;
                bit_d   = '0;
                state_d = StShift;
            end
            StShift: begin
                if (div_last) begin
                    div_d   = '0;
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        shreg_d = {shreg_q[30:0], 1'b0};
                        if (bit_q == 5'd31) begin
                            bit_d   = '0;
                            state_d = StGap;
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                    end
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            StGap: begin
                if (div_last) begin
                    div_d   = '0;
                    done_d  = ~init_q;
                    state_d = StIdle;
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset; reset also aborts any frame.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
`ifdef SPI_DAC_INIT_EN
            state_q <= StInit;
`else
            state_q <= StIdle;
`endif
            div_q   <= '0;
            phase_q <= 1'b0;
            bit_q   <= '0;
            shreg_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            done_q  <= done_d;
            err_q   <= err_d;
            init_q  <= init_d;
        end
    end

    // SPI pins decoded from registered state only; idle levels outside LOAD/SHIFT.
    always_comb begin
        cs   = 1'b1;
        mosi = 1'b0;
        sclk = CPOL;
        if (state_q == StLoad || state_q == StShift) begin
            cs   = 1'b0;
            mosi = shreg_q[31];
        end
        if (state_q == StShift && phase_q) begin
            sclk = ~CPOL;
        end
    end

    // busy is masked by rst so a held reset (INIT parked) reads as not busy.
    assign busy = (state_q != StIdle) && !rst;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_spi_dac_multi_master.sv
// Self-checking bench: random and directed write frames checked against a
// frame/timing model derived from the frame format and bit-period rules.
module tb_spi_dac_multi_master;

    localparam int unsigned DATA_W  = 12;
    localparam int unsigned NUM_CH  = 8;
    localparam int unsigned CLK_DIV = 50;
    localparam bit          CPOL    = 1'b1;
    localparam int          LAT     = 65 * CLK_DIV + 2;
    localparam int          CS_LOW  = 64 * CLK_DIV + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [3:0]        ch_addr;
    logic [DATA_W-1:0] data_in;
    logic              busy, done, err, sclk, mosi, cs;

    int checks = 0;
    int errors = 0;

    spi_dac_multi_master #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .CLK_DIV(CLK_DIV),
        .CPOL   (CPOL)
    ) dut (
        .clk_100mhz(clk),
        .rst       (rst),
        .start     (start),
        .ch_addr   (ch_addr),
        .data_in   (data_in),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs        (cs)
    );

    always #5 clk = ~clk;

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference frame: command 3 in [27:24], channel in [23:20], code left-aligned below.
    function automatic logic [31:0] model_frame(input logic [3:0] a, input logic [DATA_W-1:0] d);
        logic [31:0] f;
        f = 32'h0300_0000 + 32'(a) * 32'h0010_0000;
        f = f + 32'(d) * (32'd1 << (20 - DATA_W));
        return f;
    endfunction

    function automatic logic [3:0] rand_valid_addr();
        logic [3:0] a;
        if ($urandom_range(0, 4) == 0) a = 4'hF;
        else a = 4'($urandom_range(0, NUM_CH - 1));
        return a;
    endfunction

    // Called at the negedge on which the request (if any) was driven. Observes one
    // frame until done or busy falls, decoding bits on each leading sclk edge.
    task automatic watch_frame(input string tag, input logic [31:0] exp, input bit want_done,
                               input bit hold);
        int n = 0, cs_low = 0, hi = 0, nbits = 0;
        logic [31:0] got = '0;
        logic prev = CPOL;
        bit ended = 0, saw_err = 0, saw_done = 0;
        while (!ended) begin
            @(negedge clk);
            n++;
            if (n == 1 && !hold) start = 1'b0;
            if (hold) begin
                ch_addr = 4'($urandom_range(0, NUM_CH - 1));
                data_in = DATA_W'($urandom);
            end
            if (!cs) begin
                cs_low++;
                if (sclk != CPOL) hi++;
                if (prev == CPOL && sclk != CPOL) begin
                    got = {got[30:0], mosi};
                    nbits++;
                end
            end
            prev = sclk;
            if (err) saw_err = 1;
            if (done) saw_done = 1;
            if (done || !busy || n > 5000) ended = 1;
        end
        check_eq({tag, ".frame"}, got, exp);
        check_eq({tag, ".nbits"}, 32'(nbits), 32'd32);
        check_eq({tag, ".cs_low"}, 32'(cs_low), 32'(CS_LOW));
        check_eq({tag, ".sclk_hi"}, 32'(hi), 32'(32 * CLK_DIV));
        check_eq({tag, ".done"}, 32'(saw_done), 32'(want_done));
        check_eq({tag, ".latency"}, 32'(n), 32'(LAT));
        check_eq({tag, ".no_err"}, 32'(saw_err), 32'd0);
        if (!hold) begin
            @(negedge clk);
            check_eq({tag, ".done_pulse"}, 32'(done), 32'd0);
        end
    endtask

    task automatic send(input string tag, input logic [3:0] a, input logic [DATA_W-1:0] d);
        start   = 1'b1;
        ch_addr = a;
        data_in = d;
        watch_frame(tag, model_frame(a, d), 1'b1, 1'b0);
    endtask

    task automatic bad_addr(input logic [3:0] a);
        start   = 1'b1;
        ch_addr = a;
        data_in = DATA_W'($urandom);
        @(negedge clk);
        start = 1'b0;
        check_eq("err.pulse", 32'(err), 32'd1);
        check_eq("err.cs", 32'(cs), 32'd1);
        check_eq("err.busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_eq("err.once", 32'(err), 32'd0);
        check_eq("err.idle_cs", 32'(cs), 32'd1);
        check_eq("err.idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic after_reset(input string tag);
`ifdef SPI_DAC_INIT_EN
        watch_frame({tag, ".init"}, 32'h0800_0001, 1'b0, 1'b0);
`else
        @(negedge clk);
        check_eq({tag, ".busy"}, 32'(busy), 32'd0);
        check_eq({tag, ".cs"}, 32'(cs), 32'd1);
`endif
    endtask

    initial begin
        logic [3:0]        a2;
        logic [DATA_W-1:0] d2;
        int                quiet;
        rst     = 1'b1;
        start   = 1'b1;   // requests during reset must be ignored
        ch_addr = 4'h2;
        data_in = 12'hABC;
        repeat (3) @(negedge clk);
        check_eq("rst.cs", 32'(cs), 32'd1);
        check_eq("rst.sclk", 32'(sclk), 32'(CPOL));
        check_eq("rst.mosi", 32'(mosi), 32'd0);
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.done", 32'(done), 32'd0);
        check_eq("rst.err", 32'(err), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        after_reset("boot");

        @(negedge clk);
        send("abc", 4'h2, 12'hABC);
        bad_addr(4'h9);

        for (int i = 0; i < 5; i++) begin
            if ($urandom_range(0, 3) == 0) bad_addr(4'($urandom_range(NUM_CH, 14)));
            else send("rand", rand_valid_addr(), DATA_W'($urandom));
        end

        // Held start: one frame, then a second accepted in the done cycle.
        start   = 1'b1;
        ch_addr = rand_valid_addr();
        data_in = DATA_W'($urandom);
        watch_frame("hold1", model_frame(ch_addr, data_in), 1'b1, 1'b1);
        a2      = rand_valid_addr();
        d2      = DATA_W'($urandom);
        ch_addr = a2;
        data_in = d2;
        watch_frame("hold2", model_frame(a2, d2), 1'b1, 1'b0);

        // Reset around bit 10 of a frame.
        start   = 1'b1;
        ch_addr = 4'h5;
        data_in = 12'h123;
        @(negedge clk);
        start = 1'b0;
        repeat (20 * CLK_DIV + 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort.cs", 32'(cs), 32'd1);
        check_eq("abort.sclk", 32'(sclk), 32'(CPOL));
        check_eq("abort.mosi", 32'(mosi), 32'd0);
        check_eq("abort.busy", 32'(busy), 32'd0);
        rst = 1'b0;
`ifdef SPI_DAC_INIT_EN
        after_reset("abort");
`else
        quiet = 0;
        repeat (LAT + 100) begin
            @(negedge clk);
            if (done || !cs) quiet++;
        end
        check_eq("abort.no_done", 32'(quiet), 32'd0);
`endif
        send("recover", rand_valid_addr(), DATA_W'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
